// File: rtl/csa_pkg.sv
// ============================================================================
// Package     : csa_pkg
// Description : State encoding and sizing helper shared by the csa_resolve slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package csa_pkg;

  localparam logic [1:0] CSA_IDLE = 2'd0;
  localparam logic [1:0] CSA_BUSY = 2'd1;
  localparam logic [1:0] CSA_DONE = 2'd2;

  // Ceiling log2; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage : csa_pkg

`default_nettype wire

// File: rtl/csa_seg_add.sv
// ============================================================================
// Module      : csa_seg_add
// Description : Combinational SEGW-bit adder with carry in and carry out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csa_seg_add #(
  parameter int SEGW = 4
) (
  input  logic [SEGW-1:0] a_i,
  input  logic [SEGW-1:0] b_i,
  input  logic            c_i,
  output logic [SEGW-1:0] sum_o,
  output logic            c_o
);

  assign {c_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{SEGW{1'b0}}, c_i};

endmodule : csa_seg_add

`default_nettype wire

// File: rtl/csa_resolve.sv
// ============================================================================
// Module      : csa_resolve
// Description : Multi-cycle carry-propagate stage resolving a 4:2 compressor's
//               redundant (s, c, cout) output into a binary sum, SEGW bits/cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csa_resolve
  import csa_pkg::*;
#(
  parameter int DW   = 8,
  parameter int SEGW = 4
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_s,
  input  logic [DW-1:0] in_c,
  input  logic          in_cout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW+1:0] out_sum
);

  localparam int NSEG = DW / SEGW;
  localparam int IDXW = (clog2(NSEG) < 1) ? 1 : clog2(NSEG);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NSEG - 1);

  if (DW % SEGW != 0) begin : g_width_chk
    $error("csa_resolve: DW must be a multiple of SEGW");
  end

  logic [1:0]      state_q;
  logic [DW-1:0]   a_q;
  logic [DW-1:0]   b_q;
  logic [1:0]      hi_q;
  logic            carry_q;
  logic [IDXW-1:0] idx_q;
  logic [IDXW-1:0] idx_d;
  logic [DW+1:0]   sum_q;
  logic            out_valid_q;

  logic [31:0]     w_base;
  logic [SEGW-1:0] w_seg_sum;
  logic            w_seg_cout;
  logic [1:0]      w_hi_sum;

  assign w_base = 32'(idx_q) * 32'(SEGW);
  assign idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

  csa_seg_add #(
    .SEGW (SEGW)
  ) u_seg_add (
    .a_i   (a_q[w_base +: SEGW]),
    .b_i   (b_q[w_base +: SEGW]),
    .c_i   (carry_q),
    .sum_o (w_seg_sum),
    .c_o   (w_seg_cout)
  );

  // Top two result bits: c[DW-1] and cout share weight 2^DW, plus the final segment carry.
  assign w_hi_sum = 2'(hi_q[1]) + 2'(hi_q[0]) + 2'(w_seg_cout);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= CSA_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      hi_q        <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        CSA_IDLE: begin
          if (in_valid) begin
            a_q     <= in_s;
            b_q     <= {in_c[DW-2:0], 1'b0};
            hi_q    <= {in_c[DW-1], in_cout};
            carry_q <= 1'b0;
            idx_q   <= '0;
            state_q <= CSA_BUSY;
          end
        end
        CSA_BUSY: begin
          sum_q[w_base +: SEGW] <= w_seg_sum;
          carry_q               <= w_seg_cout;
          idx_q                 <= idx_d;
          if (idx_q == IDX_LAST) begin
            sum_q[DW+1:DW] <= w_hi_sum;
            out_valid_q    <= 1'b1;
            state_q        <= CSA_DONE;
          end
        end
        CSA_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= CSA_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= CSA_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == CSA_IDLE);
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;

endmodule : csa_resolve

`default_nettype wire
